fifo_uart_tx: RTL and testbench

Downstream drain stage for the synchronous FIFO. Pops one word at a time through the FIFO read port (`rd_en`/`empty`/`data_out`) and transmits it as an asynchronous serial frame: 1 start bit, WIDTH data bits LSB first, 1 stop bit, no parity. Gives the team a UART-style egress path for buffered bytes, paced by a fixed clock divider.

---
 rtl/fifo_uart_tx.sv | 135 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO one word at a time and sends each
// word as an 8N1-style serial frame (1 start, WIDTH data LSB first, 1 stop).
//
// Handshake: the FIFO read port has no ready/valid pair. A pop is committed
// when IDLE samples tx_en && !fifo_empty. fifo_rd_en is then high for exactly
// the one READ cycle, and the popped word is taken from fifo_data in the
// following LATCH cycle. fifo_empty is not consulted again until the next IDLE.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               baud_end;
    logic               timed_state;

    // Next-state, datapath and registered-tx decode.
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        frame_count_d = frame_count_q;
        baud_end      = (baud_q == BAUD_LAST);
        timed_state   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

        case (state_q)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shreg_d = fifo_data;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Baud counter restarts on every state change and at each bit boundary.
        if ((state_d != state_q) || baud_end || !timed_state) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        // tx follows the state being entered so the line is glitch-free.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            shreg_q       <= '0;
            tx_q          <= 1'b1;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shreg_q       <= shreg_d;
            tx_q          <= tx_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_rd_en  = (state_q == S_READ);
    assign busy        = (state_q != S_IDLE);
    assign tx          = tx_q;
    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO read-port model, serial frame capture and
// directed scenario tasks, plus a CLKS_PER_BIT=2 instance for the counter wrap.
module tb_fifo_uart_tx;

    localparam int W     = 8;
    localparam int N     = 16;
    localparam int N2    = 2;
    localparam int FRAME = (W + 2) * N + 3;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        tx_en = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] frame_count;
    logic [2:0]  dbg_state;

    // Second DUT (fast baud) signals
    logic        tx_en2 = 1'b0;
    logic        fifo_empty2 = 1'b0;
    logic [7:0]  fifo_data2 = 8'h55;
    logic        fifo_rd_en2;
    logic        tx2;
    logic        busy2;
    logic [15:0] frame_count2;
    logic [2:0]  dbg_state2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // FIFO model: one-cycle read latency, push from tasks, pop from rd_en
    logic [7:0] mem [0:63];
    int push_cnt = 0;
    int pop_cnt = 0;
    int rd_cnt = 0;
    int rd_viol = 0;
    int last_rd_cyc = -1;
    logic rd_prev = 1'b0;
    logic [W-1:0] exp_q[$];

    assign fifo_empty = (push_cnt == pop_cnt);

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frame_count(frame_count), .dbg_state(dbg_state)
    );

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(N2)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty2),
        .fifo_data(fifo_data2), .fifo_rd_en(fifo_rd_en2), .tx(tx2), .busy(busy2),
        .frame_count(frame_count2), .dbg_state(dbg_state2)
    );

    // FIFO read port model and pop monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_prev <= fifo_rd_en;
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (fifo_empty || rd_prev) rd_viol <= rd_viol + 1;
            if (!fifo_empty) begin
                fifo_data <= mem[pop_cnt[5:0]];
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [7:0] v);
        mem[push_cnt[5:0]] = v;
        push_cnt = push_cnt + 1;
    endtask

    // Waits for a start bit, then samples one frame; called at a negedge.
    task automatic capture_frame(output logic [7:0] d, output int start_c,
                                 output bit shape_ok, output bit busy_ok,
                                 output bit found);
        int n;
        logic [7:0] v;
        n = 0;
        v = '0;
        shape_ok = 1'b1;
        busy_ok = 1'b1;
        found = 1'b0;
        start_c = -1;
        while (tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tx === 1'b0) begin
            found = 1'b1;
            start_c = cyc;
            for (int i = 0; i < N; i++) begin
                if (tx !== 1'b0) shape_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
            end
            for (int k = 0; k < W; k++) begin
                v[k] = tx;
                for (int i = 0; i < N; i++) begin
                    if (tx !== v[k]) shape_ok = 1'b0;
                    if (busy !== 1'b1) busy_ok = 1'b0;
                    @(negedge clk);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (tx !== 1'b1) shape_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
            end
        end
        d = v;
    endtask

    task automatic test_reset();
        int bad_tx, bad_busy, bad_rd, bad_fc, bad_st;
        bad_tx = 0; bad_busy = 0; bad_rd = 0; bad_fc = 0; bad_st = 0;
        rst = 1'b1;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_rd_en !== 1'b0) bad_rd++;
            if (frame_count !== 16'h0000) bad_fc++;
            if (dbg_state !== 3'd0) bad_st++;
        end
        checks++; if (bad_tx !== 0) begin failures++; $display("FAIL reset_tx: %0d cycles with tx not 1, expected 0", bad_tx); end
        checks++; if (bad_busy !== 0) begin failures++; $display("FAIL reset_busy: %0d cycles with busy set, expected 0", bad_busy); end
        checks++; if (bad_rd !== 0) begin failures++; $display("FAIL reset_rd_en: %0d cycles with rd_en set, expected 0", bad_rd); end
        checks++; if (bad_fc !== 0) begin failures++; $display("FAIL reset_frame_count: %0d cycles nonzero, expected 0", bad_fc); end
        checks++; if (bad_st !== 0) begin failures++; $display("FAIL reset_state: %0d cycles not IDLE, expected 0", bad_st); end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        int sc, rd0;
        bit shape_ok, busy_ok, found;
        rd0 = rd_cnt;
        push_word(8'hA5);
        tx_en = 1'b1;
        capture_frame(d, sc, shape_ok, busy_ok, found);
        tx_en = 1'b0;
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL single_found: got %0d expected 1", found); end
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", d); end
        checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL single_shape: got %0d expected 1", shape_ok); end
        checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL single_busy_in_frame: got %0d expected 1", busy_ok); end
        checks++; if (sc !== last_rd_cyc + 2) begin failures++; $display("FAIL single_start_latency: start cycle %0d expected %0d", sc, last_rd_cyc + 2); end
        checks++; if (rd_cnt - rd0 !== 1) begin failures++; $display("FAIL single_pops: got %0d expected 1", rd_cnt - rd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_frame_count: got %0d expected 1", frame_count); end
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_idle: got %b expected 1", tx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [W-1:0] e;
        logic [15:0] exp_fc;
        int sc [3];
        int rd0;
        bit shape_ok, busy_ok, found;
        rd0 = rd_cnt;
        exp_fc = frame_count + 16'd3;
        push_word(8'h00); exp_q.push_back(8'h00);
        push_word(8'hFF); exp_q.push_back(8'hFF);
        push_word(8'h3C); exp_q.push_back(8'h3C);
        tx_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture_frame(d, sc[f], shape_ok, busy_ok, found);
            e = exp_q.pop_front();
            checks++; if (d !== e || found !== 1'b1) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", f, d, e); end
            checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL b2b_shape%0d: got %0d expected 1", f, shape_ok); end
        end
        tx_en = 1'b0;
        checks++; if (sc[1] - sc[0] !== FRAME) begin failures++; $display("FAIL b2b_period01: got %0d expected %0d", sc[1] - sc[0], FRAME); end
        checks++; if (sc[2] - sc[1] !== FRAME) begin failures++; $display("FAIL b2b_period12: got %0d expected %0d", sc[2] - sc[1], FRAME); end
        repeat (5) @(negedge clk);
        checks++; if (rd_cnt - rd0 !== 3) begin failures++; $display("FAIL b2b_pops: got %0d expected 3", rd_cnt - rd0); end
        checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL b2b_frame_count: got %0d expected %0d", frame_count, exp_fc); end
        checks++; if (rd_viol !== 0) begin failures++; $display("FAIL b2b_rd_rules: got %0d violations expected 0", rd_viol); end
    endtask

    task automatic test_tx_en_gating();
        logic [7:0] d;
        int sc, rd0, busy_bad;
        bit shape_ok, busy_ok, found;
        busy_bad = 0;
        tx_en = 1'b0;
        rd0 = rd_cnt;
        push_word(8'hC3);
        push_word(8'h99);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_bad++;
        end
        checks++; if (rd_cnt !== rd0) begin failures++; $display("FAIL gate_no_pop: got %0d pops expected 0", rd_cnt - rd0); end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL gate_busy: %0d busy cycles expected 0", busy_bad); end
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        capture_frame(d, sc, shape_ok, busy_ok, found);
        checks++; if (d !== 8'hC3 || shape_ok !== 1'b1) begin failures++; $display("FAIL gate_frame: got %h expected c3", d); end
        repeat (100) @(negedge clk);
        checks++; if (rd_cnt - rd0 !== 1) begin failures++; $display("FAIL gate_single_pop: got %0d expected 1", rd_cnt - rd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_idle: busy %b expected 0", busy); end
        push_cnt = pop_cnt;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int sc, n, rd1;
        bit shape_ok, busy_ok, found;
        n = 0;
        push_word(8'h5A);
        tx_en = 1'b1;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_en = 1'b0;
        repeat (N + 3 * N + 4) @(negedge clk);
        checks++; if (dbg_state !== 3'd4) begin failures++; $display("FAIL mid_in_data: state %0d expected 4", dbg_state); end
        rd1 = rd_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_tx: got %b expected 1", tx); end
        checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL mid_frame_count: got %0d expected 0", frame_count); end
        push_word(8'h11);
        tx_en = 1'b1;
        @(negedge clk);
        checks++; if (rd_cnt !== rd1) begin failures++; $display("FAIL mid_no_pop_in_reset: got %0d expected 0", rd_cnt - rd1); end
        rst = 1'b0;
        capture_frame(d, sc, shape_ok, busy_ok, found);
        tx_en = 1'b0;
        checks++; if (d !== 8'h11 || shape_ok !== 1'b1 || found !== 1'b1) begin failures++; $display("FAIL mid_after_frame: got %h expected 11", d); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL mid_after_count: got %0d expected 1", frame_count); end
        checks++; if (rd_cnt - rd1 !== 1) begin failures++; $display("FAIL mid_after_pops: got %0d expected 1", rd_cnt - rd1); end
    endtask

    task automatic test_counter_wrap();
        int n, c1, c2;
        n = 0;
        @(negedge clk);
        force dut2.frame_count_q = 16'hFFFE;
        @(negedge clk);
        release dut2.frame_count_q;
        tx_en2 = 1'b1;
        while (frame_count2 === 16'hFFFE && n < 200) begin
            @(negedge clk);
            n++;
        end
        c1 = cyc;
        checks++; if (frame_count2 !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff: got %h expected ffff", frame_count2); end
        while (frame_count2 === 16'hFFFF && n < 400) begin
            @(negedge clk);
            n++;
        end
        c2 = cyc;
        checks++; if (frame_count2 !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h expected 0000", frame_count2); end
        checks++; if (c2 - c1 !== (W + 2) * N2 + 3) begin failures++; $display("FAIL wrap_period: got %0d expected %0d", c2 - c1, (W + 2) * N2 + 3); end
        tx_en2 = 1'b0;
        n = 0;
        while (busy2 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++; if (dbg_state2 !== 3'd0 || tx2 !== 1'b1 || fifo_rd_en2 !== 1'b0) begin failures++; $display("FAIL wrap_idle: state %0d tx %b rd %b expected 0 1 0", dbg_state2, tx2, fifo_rd_en2); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_tx_en_gating();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
